payload_rd_slave: RTL

Slave end of the payload read bus: owns the payload word memory and answers a master's packet reads. A write port from the packet receiver fills words. The block returns data/byteCount/isLast one cycle after each address. It tracks per-packet read state, releases words on destructive reads, and keeps an occupancy count for the allocator. It sits between the payload memory and any dispatcher/egress block holding the bus Master side.

---
 rtl/payload_rd_slave_if.sv | 23 ++
 rtl/payload_rd_slave.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/payload_rd_slave_if.sv
// rtl/payload_rd_slave_if.sv - payload read bus between a dispatcher (Master) and the payload memory (Slave)
interface PayloadRdBus #(
   parameter int AW     = 8,
   parameter int DATA_W = 64,
   parameter int BC_W   = 4
);
   logic              isFirst;
   logic [AW-1:0]     address;
   logic              isDestructive;
   logic [DATA_W-1:0] data;
   logic [BC_W-1:0]   byteCount;
   logic              isLast;

   modport Master (
      output isFirst, address, isDestructive,
      input  data, byteCount, isLast
   );

   modport Slave (
      input  isFirst, address, isDestructive,
      output data, byteCount, isLast
   );
endinterface

// File: rtl/payload_rd_slave.sv
// rtl/payload_rd_slave.sv - payload word memory answering packet reads with 1-cycle latency
// Tracks per-word occupancy, releases words on destructive reads and flags sequence/empty errors.
module payload_rd_slave #(
   parameter  int DEPTH  = 256,
   parameter  int DATA_W = 64,
   parameter  int BC_W   = 4,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   PayloadRdBus.Slave        bus,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [BC_W-1:0]   wr_byte_count,
   input  logic              wr_is_last,
   output logic              rel_valid,
   output logic [AW-1:0]     rel_addr,
   output logic [AW:0]       used_count,
   output logic              seq_err,
   output logic              empty_err
);

   typedef enum logic {IDLE, READING} state_t;

   logic [DATA_W-1:0] mem_data [DEPTH];
   logic [BC_W-1:0]   mem_bc   [DEPTH];
   logic              mem_last [DEPTH];

   state_t            state_q, state_d;
   logic [DEPTH-1:0]  occ_q, occ_d;
   logic [AW:0]       used_q, used_d;
   logic [AW-1:0]     exp_q, exp_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [BC_W-1:0]   bc_q, bc_d;
   logic              last_q, last_d;
   logic              rel_valid_q, rel_valid_d;
   logic [AW-1:0]     rel_addr_q, rel_addr_d;
   logic              seq_err_q, seq_err_d;
   logic              empty_err_q, empty_err_d;

   logic issue;
   logic rd_occ;
   logic wr_hit;
   logic release_now;
   logic wr_new;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_data[wr_addr] <= wr_data;
         mem_bc[wr_addr]   <= wr_byte_count;
         mem_last[wr_addr] <= wr_is_last;
      end
   end

   always_comb begin
      // In READING a word is returned every cycle; last_q marks the end of the packet.
      issue       = bus.isFirst || ((state_q == READING) && !last_q);
      rd_occ      = occ_q[bus.address];
      wr_hit      = wr_en && (wr_addr == bus.address);
      release_now = issue && bus.isDestructive && rd_occ && !wr_hit;
      wr_new      = wr_en && !occ_q[wr_addr];

      state_d     = state_q;
      exp_d       = exp_q;
      data_d      = '0;
      bc_d        = '0;
      last_d      = 1'b0;
      rel_valid_d = 1'b0;
      rel_addr_d  = '0;
      seq_err_d   = 1'b0;
      empty_err_d = 1'b0;

      if (bus.isFirst) begin
         state_d = READING;
      end else if ((state_q == READING) && last_q) begin
         state_d = IDLE;
      end

      if (issue) begin
         exp_d = bus.address + 1'b1;
         if ((state_q == READING) && !bus.isFirst && (bus.address != exp_q)) begin
            seq_err_d = 1'b1;
         end
         if (rd_occ) begin
            data_d = mem_data[bus.address];
            bc_d   = mem_bc[bus.address];
            last_d = mem_last[bus.address];
         end else begin
            last_d      = 1'b1;
            empty_err_d = 1'b1;
         end
      end

      if (release_now) begin
         rel_valid_d = 1'b1;
         rel_addr_d  = bus.address;
      end

      // Write after release so a same-address write keeps the word occupied.
      occ_d = occ_q;
      if (release_now) begin
         occ_d[bus.address] = 1'b0;
      end
      if (wr_en) begin
         occ_d[wr_addr] = 1'b1;
      end

      used_d = used_q + {{AW{1'b0}}, wr_new} - {{AW{1'b0}}, release_now};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         occ_q       <= '0;
         used_q      <= '0;
         exp_q       <= '0;
         data_q      <= '0;
         bc_q        <= '0;
         last_q      <= 1'b0;
         rel_valid_q <= 1'b0;
         rel_addr_q  <= '0;
         seq_err_q   <= 1'b0;
         empty_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         occ_q       <= occ_d;
         used_q      <= used_d;
         exp_q       <= exp_d;
         data_q      <= data_d;
         bc_q        <= bc_d;
         last_q      <= last_d;
         rel_valid_q <= rel_valid_d;
         rel_addr_q  <= rel_addr_d;
         seq_err_q   <= seq_err_d;
         empty_err_q <= empty_err_d;
      end
   end

   assign bus.data      = data_q;
   assign bus.byteCount = bc_q;
   assign bus.isLast    = last_q;
   assign rel_valid     = rel_valid_q;
   assign rel_addr      = rel_addr_q;
   assign used_count    = used_q;
   assign seq_err       = seq_err_q;
   assign empty_err     = empty_err_q;

endmodule
